// File: rtl/controller_pkg.sv
// Shared constants for the phase-driven instruction-cycle controller.
// Holds the phase encodings, the VeriRISC opcode values and the bit
// positions of the nine datapath strobes inside the packed control word.
package controller_pkg;

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Control word layout, MSB first: {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}
  localparam int CW_W      = 9;
  localparam int CW_SEL    = 8;
  localparam int CW_RD     = 7;
  localparam int CW_LD_IR  = 6;
  localparam int CW_HALT   = 5;
  localparam int CW_INC_PC = 4;
  localparam int CW_LD_AC  = 3;
  localparam int CW_LD_PC  = 2;
  localparam int CW_WR     = 1;
  localparam int CW_DATA_E = 0;

endpackage

// File: rtl/controller_op_decode.sv
// Combinational opcode classifier.
// Ports:
//   opcode_i  - IR opcode field, OPCODE_W bits
//   halt_o    - HLT instruction
//   skz_o     - skip-if-zero instruction
//   aluop_o   - ADD/AND/XOR/LDA (reads memory operand, loads AC)
//   sto_o     - store AC to memory
//   jmp_o     - jump
//   illegal_o - opcode value 8 or above; all class outputs forced low
module controller_op_decode
  import controller_pkg::*;
#(
  parameter int OPCODE_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic                halt_o,
  output logic                skz_o,
  output logic                aluop_o,
  output logic                sto_o,
  output logic                jmp_o,
  output logic                illegal_o
);

  // Zero-extend so the >=8 test also works when OPCODE_W is exactly 3.
  logic [31:0] op_ext;
  assign op_ext = 32'(opcode_i);

  always_comb begin
    halt_o    = 1'b0;
    skz_o     = 1'b0;
    aluop_o   = 1'b0;
    sto_o     = 1'b0;
    jmp_o     = 1'b0;
    illegal_o = (op_ext > 32'd7);
    if (!illegal_o) begin
      case (op_ext[2:0])
        OP_HLT:                         halt_o  = 1'b1;
        OP_SKZ:                         skz_o   = 1'b1;
        OP_ADD, OP_AND, OP_XOR, OP_LDA: aluop_o = 1'b1;
        OP_STO:                         sto_o   = 1'b1;
        OP_JMP:                         jmp_o   = 1'b1;
        default:                        ;
      endcase
    end
  end

endmodule

// File: rtl/controller_seq.sv
// Phase-driven VeriRISC controller with internal 8-phase counter,
// memory wait states, resumable halt and sticky illegal-opcode flag.
// Ports:
//   clk, rst         - clock (rising edge), async active-high reset
//   opcode           - IR opcode field, stable from phase 3 onward
//   zero             - accumulator zero flag
//   mem_rdy          - completes a memory-access phase
//   resume           - leave the halted state
//   sel..data_e      - datapath strobes, combinational from phase/opcode/zero
//   phase            - current phase 0..7
//   halted           - frozen in halt
//   illegal_op       - sticky illegal-opcode indication
//
// phase | meaning
// 0     | INST_ADDR  : PC onto address bus
// 1     | INST_FETCH : instruction read (memory access)
// 2     | INST_LOAD  : load IR
// 3     | IDLE       : IR settles
// 4     | OP_ADDR    : PC increment, halt decision
// 5     | OP_FETCH   : operand read (memory access for ALU ops)
// 6     | ALU_OP     : ALU / skip / jump
// 7     | STORE      : AC load or memory write (memory access for STO)
// halted_q overlays phase 4 while frozen.
module controller_seq
  import controller_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_rdy,
  input  logic                resume,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                halt,
  output logic                inc_pc,
  output logic                ld_ac,
  output logic                ld_pc,
  output logic                wr,
  output logic                data_e,
  output logic [2:0]          phase,
  output logic                halted,
  output logic                illegal_op
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [2:0]      phase_q;
  logic [3:0]      wait_cnt_q;
  logic            halted_q;
  logic            illegal_q;
  logic            dec_halt, dec_skz, dec_aluop, dec_sto, dec_jmp, dec_illegal;
  logic            mem_phase;
  logic [CW_W-1:0] cw;

  controller_op_decode #(.OPCODE_W(OPCODE_W)) u_op_decode (
    .opcode_i  (opcode),
    .halt_o    (dec_halt),
    .skz_o     (dec_skz),
    .aluop_o   (dec_aluop),
    .sto_o     (dec_sto),
    .jmp_o     (dec_jmp),
    .illegal_o (dec_illegal)
  );

  assign mem_phase = (phase_q == PH_INST_FETCH)
                   | ((phase_q == PH_OP_FETCH) & dec_aluop)
                   | ((phase_q == PH_STORE)    & dec_sto);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= PH_INST_ADDR;
      wait_cnt_q <= 4'd0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (halted_q) begin
      if (resume) begin
        halted_q <= 1'b0;
        phase_q  <= PH_OP_FETCH;
      end
    end else begin
      if ((phase_q == PH_OP_ADDR) && dec_illegal)
        illegal_q <= 1'b1;
      if ((phase_q == PH_OP_ADDR) && dec_halt) begin
        halted_q <= 1'b1;
      end else if (!mem_phase || ((wait_cnt_q == WS) && mem_rdy)) begin
        phase_q    <= phase_q + 3'd1;
        wait_cnt_q <= 4'd0;
      end else if (wait_cnt_q != WS) begin
        wait_cnt_q <= wait_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    cw = '0;
    if (halted_q) begin
      // PC frozen: only the halt indication survives.
      cw[CW_HALT] = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR:  cw[CW_SEL] = 1'b1;
        PH_INST_FETCH: begin
          cw[CW_SEL] = 1'b1;
          cw[CW_RD]  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          cw[CW_SEL]   = 1'b1;
          cw[CW_RD]    = 1'b1;
          cw[CW_LD_IR] = 1'b1;
        end
        PH_OP_ADDR: begin
          cw[CW_HALT]   = dec_halt;
          cw[CW_INC_PC] = 1'b1;
        end
        PH_OP_FETCH: cw[CW_RD] = dec_aluop;
        PH_ALU_OP: begin
          cw[CW_RD]     = dec_aluop;
          cw[CW_INC_PC] = dec_skz & zero;
          cw[CW_LD_PC]  = dec_jmp;
          cw[CW_DATA_E] = dec_sto;
        end
        default: begin
          cw[CW_RD]     = dec_aluop;
          cw[CW_LD_AC]  = dec_aluop;
          cw[CW_LD_PC]  = dec_jmp;
          cw[CW_WR]     = dec_sto;
          cw[CW_DATA_E] = dec_sto;
        end
      endcase
    end
  end

  assign sel        = cw[CW_SEL];
  assign rd         = cw[CW_RD];
  assign ld_ir      = cw[CW_LD_IR];
  assign halt       = cw[CW_HALT];
  assign inc_pc     = cw[CW_INC_PC];
  assign ld_ac      = cw[CW_LD_AC];
  assign ld_pc      = cw[CW_LD_PC];
  assign wr         = cw[CW_WR];
  assign data_e     = cw[CW_DATA_E];
  assign phase      = phase_q;
  assign halted     = halted_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_controller_seq.sv
// Random-stimulus bench: two controller instances (3-bit opcode / no wait
// states, and 4-bit opcode / two wait states) share the inputs and are
// compared every cycle against an instruction-cycle reference model.
module tb_controller_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero, mem_rdy, resume;

  logic       a_sel, a_rd, a_ld_ir, a_halt, a_inc_pc, a_ld_ac, a_ld_pc, a_wr, a_data_e;
  logic [2:0] a_phase;
  logic       a_halted, a_illegal;
  logic       b_sel, b_rd, b_ld_ir, b_halt, b_inc_pc, b_ld_ac, b_ld_pc, b_wr, b_data_e;
  logic [2:0] b_phase;
  logic       b_halted, b_illegal;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  controller_seq #(.OPCODE_W(3), .WAIT_STATES(0)) u_dut_a (
    .clk(clk), .rst(rst), .opcode(opcode[2:0]), .zero(zero), .mem_rdy(mem_rdy),
    .resume(resume), .sel(a_sel), .rd(a_rd), .ld_ir(a_ld_ir), .halt(a_halt),
    .inc_pc(a_inc_pc), .ld_ac(a_ld_ac), .ld_pc(a_ld_pc), .wr(a_wr), .data_e(a_data_e),
    .phase(a_phase), .halted(a_halted), .illegal_op(a_illegal)
  );

  controller_seq #(.OPCODE_W(4), .WAIT_STATES(2)) u_dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy),
    .resume(resume), .sel(b_sel), .rd(b_rd), .ld_ir(b_ld_ir), .halt(b_halt),
    .inc_pc(b_inc_pc), .ld_ac(b_ld_ac), .ld_pc(b_ld_pc), .wr(b_wr), .data_e(b_data_e),
    .phase(b_phase), .halted(b_halted), .illegal_op(b_illegal)
  );

  typedef struct {
    int phase;
    int dwell;   // cycles already spent in the current phase
    bit halted;
    bit illegal;
  } mstate_t;

  mstate_t ms[2];
  int      ws[2]     = '{0, 2};
  int      opmask[2] = '{7, 15};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic mstate_t reset_state();
    mstate_t s;
    s.phase = 0; s.dwell = 0; s.halted = 1'b0; s.illegal = 1'b0;
    return s;
  endfunction

  // Expected {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}.
  function automatic logic [8:0] exp_cw(mstate_t s, int op, bit z);
    bit hlt = (op == 0);
    bit skz = (op == 1);
    bit alu = (op >= 2 && op <= 5);
    bit sto = (op == 6);
    bit jmp = (op == 7);
    if (s.halted) return 9'b000100000;
    case (s.phase)
      0: return 9'b100000000;
      1: return 9'b110000000;
      2, 3: return 9'b111000000;
      4: return {3'b000, hlt, 1'b1, 4'b0000};
      5: return {1'b0, alu, 7'b0};
      6: return {1'b0, alu, 2'b00, skz & z, 1'b0, jmp, 1'b0, sto};
      default: return {1'b0, alu, 3'b000, alu, jmp, sto, sto};
    endcase
  endfunction

  function automatic mstate_t step(mstate_t s, int w, int op, bit rdy, bit res);
    mstate_t n = s;
    bit access;
    if (s.halted) begin
      if (res) begin
        n.halted = 1'b0;
        n.phase  = 5;
        n.dwell  = 0;
      end
      return n;
    end
    if (s.phase == 4 && op >= 8) n.illegal = 1'b1;
    if (s.phase == 4 && op == 0) begin
      n.halted = 1'b1;
      return n;
    end
    access = (s.phase == 1) || (s.phase == 5 && op >= 2 && op <= 5) || (s.phase == 7 && op == 6);
    if (!access || (s.dwell >= w && rdy)) begin
      n.phase = (s.phase + 1) % 8;
      n.dwell = 0;
    end else begin
      n.dwell = s.dwell + 1;
    end
    return n;
  endfunction

  task automatic check_all(input int cyc);
    logic [8:0] cw_a, cw_b;
    cw_a = {a_sel, a_rd, a_ld_ir, a_halt, a_inc_pc, a_ld_ac, a_ld_pc, a_wr, a_data_e};
    cw_b = {b_sel, b_rd, b_ld_ir, b_halt, b_inc_pc, b_ld_ac, b_ld_pc, b_wr, b_data_e};
    check($sformatf("a_strobes c%0d", cyc), 32'(cw_a), 32'(exp_cw(ms[0], int'(opcode) & opmask[0], zero)));
    check($sformatf("a_phase c%0d", cyc), 32'(a_phase), 32'(ms[0].phase));
    check($sformatf("a_halted c%0d", cyc), 32'(a_halted), 32'(ms[0].halted));
    check($sformatf("a_illegal c%0d", cyc), 32'(a_illegal), 32'(ms[0].illegal));
    check($sformatf("b_strobes c%0d", cyc), 32'(cw_b), 32'(exp_cw(ms[1], int'(opcode) & opmask[1], zero)));
    check($sformatf("b_phase c%0d", cyc), 32'(b_phase), 32'(ms[1].phase));
    check($sformatf("b_halted c%0d", cyc), 32'(b_halted), 32'(ms[1].halted));
    check($sformatf("b_illegal c%0d", cyc), 32'(b_illegal), 32'(ms[1].illegal));
  endtask

  initial begin
    rst     = 1'b1;
    opcode  = 4'd2;
    zero    = 1'b0;
    mem_rdy = 1'b1;
    resume  = 1'b0;
    ms[0] = reset_state();
    ms[1] = reset_state();
    #3;
    check_all(-1);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      if ($urandom_range(0, 3) == 0) opcode = 4'($urandom_range(0, 15));
      zero    = 1'($urandom_range(0, 1));
      mem_rdy = ($urandom_range(0, 3) != 0);
      resume  = ($urandom_range(0, 5) == 0);
      #1;
      check_all(cyc);
      // Periodic asynchronous reset in mid-cycle, held across the next edge.
      if (cyc % 250 == 249) begin
        rst = 1'b1;
        #1;
        ms[0] = reset_state();
        ms[1] = reset_state();
        check_all(cyc);
      end
      @(posedge clk);
      if (!rst) begin
        for (int d = 0; d < 2; d++)
          ms[d] = step(ms[d], ws[d], int'(opcode) & opmask[d], mem_rdy, resume);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/controller_seq.md
Name: controller_seq

Overview:
Parametrised successor to the VeriRISC phase-driven controller. It owns the 8-phase instruction cycle counter internally instead of taking `phase` as an input. It adds memory wait-state handling, a resumable halt state, a configurable opcode width, and sticky illegal-opcode detection. It drives the same nine datapath control strobes to the PC, IR, AC, ALU and memory interface.

Parameters:
OPCODE_W, 3, opcode width; must be >= 3; opcodes 8 and above are illegal.
WAIT_STATES, 0, minimum extra cycles spent in each memory-access phase (0..15).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
opcode  in  OPCODE_W  current IR opcode field; stable from phase 3 onward.
zero  in  1  accumulator zero flag.
mem_rdy  in  1  memory ready; completes a memory-access phase.
resume  in  1  single-cycle request to leave the halted state.
sel  out  1  address mux selects PC.
rd  out  1  memory read.
ld_ir  out  1  load IR.
halt  out  1  halt indication.
inc_pc  out  1  increment PC.
ld_ac  out  1  load accumulator.
ld_pc  out  1  load PC (jump).
wr  out  1  memory write.
data_e  out  1  drive data bus from AC.
phase  out  3  current phase, 0..7.
halted  out  1  controller is frozen in the halt state.
illegal_op  out  1  sticky: an illegal opcode has been decoded.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: phase=0, wait_cnt=0, halted=0, illegal_op=0. Outputs take the phase-0 decode: sel=1, all other strobes 0. This applies immediately on `rst`, with no clock edge needed.
- Opcode decode: HALT=op==0, SKZ=op==1, ALUOP=op in 2..5, STO=op==6, JMP=op==7. Opcodes 8 and above decode to all-zero.
- Output decode: outputs are combinational from the registered phase plus opcode and zero.
  - 0 INST_ADDR: sel.
  - 1 INST_FETCH: sel, rd.
  - 2 INST_LOAD: sel, rd, ld_ir.
  - 3 IDLE: sel, rd, ld_ir.
  - 4 OP_ADDR: halt=HALT, inc_pc=1.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP, inc_pc=SKZ&zero, ld_pc=JMP, data_e=STO.
  - 7 STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
- Advance rule: phase advances by 1 each cycle and wraps 7->0, except in stall and halt conditions below.
- Memory-access phases: phase 1 always; phase 5 when ALUOP; phase 7 when STO.
  - wait_cnt is 0 on entry and increments each cycle spent in the phase, saturating at WAIT_STATES.
  - Advance occurs when wait_cnt==WAIT_STATES and mem_rdy=1.
  - wait_cnt clears on advance.
  - With mem_rdy=1, such a phase lasts WAIT_STATES+1 cycles. mem_rdy low holds the phase indefinitely.
  - Non-access phases ignore mem_rdy.
- Halt:
  - At the end of phase 4 with HALT, halted is set and phase stays 4. halt=1 and inc_pc=1 are held for the first phase-4 cycle only.
  - While halted, inc_pc=0 (PC frozen), halt=1, and all other strobes are 0.
  - `resume`=1 while halted: the next edge clears halted and sets phase=5.
  - `resume` while not halted is ignored. `resume` on the same edge that sets halted is ignored.
- illegal_op: set on the phase-4 edge when opcode>=8. The instruction then executes as a NOP. The flag clears only on rst.
- Reset mid-operation, including during a stall or while halted, returns to phase 0 immediately. No partial strobes persist.

Decomposition:
- Shared package `controller_pkg`:
  - phase localparams (PH_INST_ADDR..PH_STORE),
  - opcode constants (OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP),
  - control-word bit indices for {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}.
- One sub-module, `controller_op_decode` (OPCODE_W): combinational opcode -> {HALT,SKZ,ALUOP,STO,JMP,illegal}.
- The top level holds the phase counter, wait counter, halt latch and output decode.

Test Plan:
- WAIT_STATES=0, mem_rdy=1, opcode=2, 9 clocks after reset release -> phase sequence 0..7,0. ld_ac=1 only in phase 7. rd=1 in phases 1,2,3,5,6,7.
- WAIT_STATES=2, mem_rdy=1, opcode=6 -> phase 1 lasts 3 cycles, phase 5 lasts 1 cycle, phase 7 lasts 3 cycles with wr=data_e=1. Then mem_rdy=0 in phase 7 -> phase holds until mem_rdy=1.
- opcode=0 -> phase holds at 4, halted=1, halt=1, inc_pc=1 for one cycle only. resume pulse after 5 cycles -> next cycle phase=5, halted=0.
- opcode=1: zero=1 -> inc_pc=1 in phases 4 and 6. zero=0 -> inc_pc=1 in phase 4 only.
- OPCODE_W=4, opcode=9 -> all op-dependent strobes 0 in phases 5-7, illegal_op=1 from the phase-4 edge and stays 1 across following instructions.
- Assert rst asynchronously mid-phase 6 with opcode=7 -> ld_pc drops, sel=1, phase=0 before the next clock edge. halted and illegal_op are cleared.
